fullword_counter_sink: RTL and testbench
========================================

// Module: fullword_counter_sink
// PURPOSE
//  Clocked consumer directly downstream of the NCL full-word counter ring.
//  Receives the dual-rail sum digits and the final carry-out of all WIDTH bit
//  stages, and drives the ring's sumcomp completion line.
//  Decodes each complete DATA wavefront into a binary word and checks that it
//  equals the previous word + 1. Presents the result on a valid/ready port.
// PARAMETERS
//  WIDTH    32  counter bit stages, i.e. number of dual-rail digits
//  SYNC     2   synchronizer flops per input rail (>=2)
//  CNTW     16  width of wave_count
// PORTS
//  clk         in   1        clock
//  init        in   1        synchronous reset, active-high
//  sum_dr      in   2*WIDTH  digit i = sum_dr[2i+1:2i]; [2i]=DATA0, [2i+1]=DATA1
//  carry_dr    in   2        final carry-out of the ring; [0]=DATA0, [1]=DATA1
//  sumcomp     out  1        1 = DATA accepted, request NULL; 0 = request DATA
//  word_q      out  WIDTH    decoded sum word
//  ovf_q       out  1        decoded carry-out captured with word_q
//  word_valid  out  1        word_q/ovf_q hold an unconsumed word
//  word_ready  in   1        consumer accepts the word when word_valid&word_ready
//  seq_err     out  1        sticky: a captured word != previous word + 1
//  ill_err     out  1        sticky: some digit showed both rails high
//  wave_count  out  CNTW     number of DATA wavefronts captured, wraps
// BEHAVIOUR
//  - Reset: init is sampled on the clk edge and overrides everything.
//    Reset values: sumcomp=0, word_q=0, ovf_q=0, word_valid=0, seq_err=0,
//    ill_err=0, wave_count=0, first=1, synchronizers=0, state=WAIT_DATA.
//  - init asserted mid-handshake aborts it. Any partly seen wavefront is
//    discarded.
//  - Input path: every rail passes through SYNC flops, giving s.
//    s_d is s delayed one cycle. "Stable" means s==s_d.
//  - Digit classes: NULL=00, DATA=01/10, ILLEGAL=11.
//    complete = all WIDTH+1 digits DATA. empty = all rails 0.
//  - FSM state WAIT_DATA (sumcomp=0):
//      - If stable and complete and output slot free, then at the next edge:
//        word_q<=DATA1 rails of sum_dr; ovf_q<=carry_dr[1]; word_valid<=1;
//        sumcomp<=1; wave_count+=1; go to WAIT_NULL.
//      - "Output slot free" means !word_valid, or word_ready this cycle.
//        Simultaneous consume and capture is allowed, with no bubble.
//      - If the slot is not free, stall in WAIT_DATA and hold sumcomp=0.
//        The ring stays blocked by the missing completion.
//      - Latency: 1 edge from stable-complete s to word_valid/sumcomp high.
//  - FSM state WAIT_NULL (sumcomp=1):
//      - If stable and empty, then next edge sumcomp<=0, go to WAIT_DATA.
//      - A partial NULL (some rails still high) keeps waiting. No timeout.
//  - Sequence check at capture:
//      - If first=1, no check; clear first.
//      - Otherwise, if the new word != (old word_q + 1) mod 2^WIDTH, set seq_err.
//      - The reference value is the last captured word, even if consumed.
//      - Wrap: all-ones -> 0 is legal.
//      - ovf_q is not compared.
//  - ill_err: set in any state on any cycle where a synchronized digit is 11.
//    A wavefront containing 11 is never complete, so it is never captured.
//  - word_valid clears on valid&ready unless a capture occurs the same edge.
//  - wave_count wraps modulo 2^CNTW.
//  - All outputs are registered. There is no combinational path from inputs to outputs.
// TESTING
//  1. init 3 cycles, then hold all rails 0 -> sumcomp=0, word_valid=0,
//     all errors 0, wave_count=0.
//  2. Drive word 0x00000005 (carry DATA0) stable, word_ready=1 ->
//     word_valid=1, word_q=5, and sumcomp=1 within SYNC+2 cycles.
//     Drive NULL -> sumcomp=0.
//  3. Drive waves 5,6,7 then 9 -> seq_err=0 after 7 and seq_err=1 after 9.
//     wave_count=4.
//  4. Drive 0xFFFFFFFF then 0x00000000 with carry DATA1 -> seq_err stays 0,
//     ovf_q=1 on the second word.
//  5. Set word_ready=0 and present two waves -> the first is captured.
//     The second stalls with sumcomp=0 after NULL. Raise word_ready ->
//     the second is captured with no bubble.
//  6. Force digit 3 to 11 -> ill_err=1 and no capture.
//     Assert init while in WAIT_NULL -> all outputs return to reset values
//     the next cycle.

Source files
------------

// File: rtl/fullword_counter_sink.sv
// Clocked sink for the NCL full-word counter ring: synchronizes the dual-rail
// sum/carry digits, captures each DATA wavefront, and checks that words increment.
module fullword_counter_sink #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SYNC  = 2,
  parameter int unsigned CNTW  = 16
) (
  input  logic               clk,
  input  logic               init,
  input  logic [2*WIDTH-1:0] sum_dr,
  input  logic [1:0]         carry_dr,
  output logic               sumcomp,
  output logic [WIDTH-1:0]   word_q,
  output logic               ovf_q,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               seq_err,
  output logic               ill_err,
  output logic [CNTW-1:0]    wave_count
);

  localparam int unsigned RAILS = 2*WIDTH + 2;

  localparam logic [0:0] WAIT_DATA = 1'b0;
  localparam logic [0:0] WAIT_NULL = 1'b1;

  logic [RAILS-1:0] sync_q [SYNC];
  logic [RAILS-1:0] s;
  logic [RAILS-1:0] s_d;
  logic [0:0]       state;
  logic             first;

  logic             complete;
  logic             illegal;
  logic             empty;
  logic             stable;
  logic             slot_free;
  logic             capture;
  logic             release_null;
  logic [WIDTH-1:0] data_word;

  // Carry-out occupies the top digit so it is classified like any sum digit.
  always_ff @(posedge clk) begin
    if (init) begin
      for (int unsigned i = 0; i < SYNC; i++) sync_q[i] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= {carry_dr, sum_dr};
      for (int unsigned i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
      s_d <= s;
    end
  end

  assign s = sync_q[SYNC-1];

  always_comb begin
    complete  = 1'b1;
    illegal   = 1'b0;
    data_word = '0;
    for (int unsigned i = 0; i <= WIDTH; i++) begin
      complete = complete & (s[2*i] ^ s[2*i+1]);
      illegal  = illegal | (s[2*i] & s[2*i+1]);
    end
    for (int unsigned i = 0; i < WIDTH; i++) data_word[i] = s[2*i+1];
  end

  assign empty        = (s == '0);
  assign stable       = (s == s_d);
  assign slot_free    = !word_valid || word_ready;
  assign capture      = (state == WAIT_DATA) && stable && complete && slot_free;
  assign release_null = (state == WAIT_NULL) && stable && empty;

  always_ff @(posedge clk) begin
    if (init) begin
      state      <= WAIT_DATA;
      sumcomp    <= 1'b0;
      word_q     <= '0;
      ovf_q      <= 1'b0;
      word_valid <= 1'b0;
      seq_err    <= 1'b0;
      ill_err    <= 1'b0;
      wave_count <= '0;
      first      <= 1'b1;
    end else begin
      if (illegal) ill_err <= 1'b1;

      if (capture) begin
        word_q     <= data_word;
        ovf_q      <= s[2*WIDTH+1];
        word_valid <= 1'b1;
        sumcomp    <= 1'b1;
        wave_count <= wave_count + CNTW'(1);
        state      <= WAIT_NULL;
        first      <= 1'b0;
        // Reference is the last captured word, whether or not it was consumed.
        if (!first && (data_word != word_q + WIDTH'(1))) seq_err <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      if (release_null) begin
        sumcomp <= 1'b0;
        state   <= WAIT_DATA;
      end
    end
  end

endmodule

// File: tb/tb_fullword_counter_sink.sv
// Scoreboard bench for fullword_counter_sink: directed wavefronts push expected
// words; a negedge monitor pops and compares on every valid&ready handshake.
module tb_fullword_counter_sink;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned CNTW  = 16;

  logic               clk;
  logic               init;
  logic [2*WIDTH-1:0] sum_dr;
  logic [1:0]         carry_dr;
  logic               sumcomp;
  logic [WIDTH-1:0]   word_q;
  logic               ovf_q;
  logic               word_valid;
  logic               word_ready;
  logic               seq_err;
  logic               ill_err;
  logic [CNTW-1:0]    wave_count;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0]  exp_q [$];
  logic [WIDTH:0]  exp_word;
  logic [CNTW-1:0] exp_count;
  int              lat;

  fullword_counter_sink #(.WIDTH(WIDTH), .SYNC(SYNC), .CNTW(CNTW)) dut (
    .clk(clk), .init(init), .sum_dr(sum_dr), .carry_dr(carry_dr),
    .sumcomp(sumcomp), .word_q(word_q), .ovf_q(ovf_q),
    .word_valid(word_valid), .word_ready(word_ready),
    .seq_err(seq_err), .ill_err(ill_err), .wave_count(wave_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none", {ovf_q, word_q});
      end else begin
        exp_word = exp_q.pop_front();
        check("word", 64'({ovf_q, word_q}), 64'(exp_word));
      end
    end
  end

  function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] w);
    logic [2*WIDTH-1:0] r;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[2*i+1] = w[i];
      r[2*i]   = ~w[i];
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_null();
    sum_dr   = '0;
    carry_dr = 2'b00;
  endtask

  task automatic drive_data(input logic [WIDTH-1:0] w, input logic c1);
    sum_dr   = encode(w);
    carry_dr = c1 ? 2'b10 : 2'b01;
  endtask

  task automatic wait_sumcomp(input logic v, output int n);
    n = 0;
    while (sumcomp !== v && n < 40) begin
      tick(1);
      n++;
    end
    check(v ? "sumcomp_rise" : "sumcomp_fall", 64'(sumcomp), 64'(v));
  endtask

  task automatic send_wave(input logic [WIDTH-1:0] w, input logic c1);
    int n;
    exp_q.push_back({c1, w});
    drive_data(w, c1);
    wait_sumcomp(1'b1, n);
    check("capture_latency", 64'(n), 64'(SYNC + 2));
    exp_count++;
    check("wave_count", 64'(wave_count), 64'(exp_count));
    drive_null();
    wait_sumcomp(1'b0, n);
    check("null_latency", 64'(n), 64'(SYNC + 2));
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick(1);
    init = 1'b0;
    exp_count = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*WIDTH-1:0] bad;
    init       = 1'b1;
    word_ready = 1'b1;
    exp_count  = '0;
    drive_null();
    tick(3);
    init = 1'b0;
    tick(2);
    check("rst_sumcomp", 64'(sumcomp), 64'(0));
    check("rst_valid", 64'(word_valid), 64'(0));
    check("rst_seq_err", 64'(seq_err), 64'(0));
    check("rst_ill_err", 64'(ill_err), 64'(0));
    check("rst_wave_count", 64'(wave_count), 64'(0));
    check("rst_word", 64'({ovf_q, word_q}), 64'(0));

    // Single wave, latency and word value.
    send_wave(32'h0000_0005, 1'b0);
    check("word_q_5", 64'(word_q), 64'h5);

    // Increment sequence then a skip.
    pulse_init();
    send_wave(32'd5, 1'b0);
    send_wave(32'd6, 1'b0);
    send_wave(32'd7, 1'b0);
    check("seq_ok_after_7", 64'(seq_err), 64'(0));
    send_wave(32'd9, 1'b0);
    check("seq_err_after_9", 64'(seq_err), 64'(1));
    check("wave_count_4", 64'(wave_count), 64'(4));

    // Wrap through all-ones, carry captured.
    pulse_init();
    send_wave(32'hFFFF_FFFE, 1'b0);
    send_wave(32'hFFFF_FFFF, 1'b0);
    send_wave(32'h0000_0000, 1'b1);
    check("seq_ok_wrap", 64'(seq_err), 64'(0));
    check("ovf_wrap", 64'(ovf_q), 64'(1));

    // Backpressure: second wave stalls until the slot frees.
    word_ready = 1'b0;
    send_wave(32'd1, 1'b0);
    exp_q.push_back({1'b0, 32'd2});
    drive_data(32'd2, 1'b0);
    tick(10);
    check("stall_sumcomp", 64'(sumcomp), 64'(0));
    check("stall_valid", 64'(word_valid), 64'(1));
    check("stall_word", 64'(word_q), 64'(1));
    check("stall_count", 64'(wave_count), 64'(exp_count));
    word_ready = 1'b1;
    tick(1);
    exp_count++;
    check("nobubble_valid", 64'(word_valid), 64'(1));
    check("nobubble_word", 64'(word_q), 64'(2));
    check("nobubble_sumcomp", 64'(sumcomp), 64'(1));
    check("nobubble_count", 64'(wave_count), 64'(exp_count));
    drive_null();
    wait_sumcomp(1'b0, lat);
    check("seq_ok_stall", 64'(seq_err), 64'(0));

    // Illegal digit 3, never captured.
    bad = encode(32'd3);
    bad[7:6] = 2'b11;
    sum_dr   = bad;
    carry_dr = 2'b01;
    tick(8);
    check("ill_err_set", 64'(ill_err), 64'(1));
    check("ill_sumcomp", 64'(sumcomp), 64'(0));
    check("ill_valid", 64'(word_valid), 64'(0));
    check("ill_count", 64'(wave_count), 64'(exp_count));
    drive_null();
    tick(6);

    // init while waiting for NULL.
    exp_q.push_back({1'b0, 32'd3});
    drive_data(32'd3, 1'b0);
    wait_sumcomp(1'b1, lat);
    check("seq_ok_3", 64'(seq_err), 64'(0));
    init = 1'b1;
    tick(1);
    check("abort_sumcomp", 64'(sumcomp), 64'(0));
    check("abort_word", 64'({ovf_q, word_q}), 64'(0));
    check("abort_valid", 64'(word_valid), 64'(0));
    check("abort_seq_err", 64'(seq_err), 64'(0));
    check("abort_ill_err", 64'(ill_err), 64'(0));
    check("abort_count", 64'(wave_count), 64'(0));
    drive_null();
    init = 1'b0;
    tick(3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
